q_tile_reader: RTL and testbench
================================

Name: q_tile_reader

Overview:
- Reader side of the Q-projection output SRAM. The Q-projection writer fills this SRAM with FP32 4x4 result tiles: 4 words of 128 bits per tile, word 0 holding lanes 0-3.
- This block reads the tiles back in order, reassembles each into a 512-bit tile and streams it downstream (attention-score stage) over a valid/ready handshake.
- It owns the SRAM port while busy.

Parameters:
- NUM_TILES, 32, number of tiles read per start.
- ADDR_W, 7, SRAM address width.
- BASE_ADDR, 0, SRAM word address of tile 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; begins a readout of NUM_TILES tiles
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last tile is accepted
- out_tile  out  512  assembled tile; word i occupies bits [128i+127:128i]
- out_valid  out  1  out_tile holds a complete tile
- out_ready  in  1  downstream accepts out_tile
- tile_idx  out  5  index of the tile currently on out_tile
- MEM_DOUT  in  128  SRAM read data
- MEM_CEB  out  1  SRAM chip enable, active-low, combinational
- MEM_WEN  out  1  SRAM write enable, active-low; constant 1
- MEM_ADDR  out  ADDR_W  SRAM address, registered
- MEM_DIN  out  128  constant 0

Behaviour:
- Reset values:
  - state IDLE.
  - busy, done, out_valid = 0.
  - MEM_CEB = 1, MEM_WEN = 1.
  - MEM_ADDR = BASE_ADDR.
  - out_tile, tile_idx, MEM_DIN = 0.
- SRAM timing:
  - A read is issued in a cycle with MEM_CEB = 0 and MEM_ADDR = a.
  - MEM_DOUT carries word a in the following cycle and is captured at the end of that cycle.
- States: IDLE, READ, LAST, PRESENT, DONE.
- IDLE:
  - start = 1 sets tile counter k = 0, MEM_ADDR = BASE_ADDR, and moves to READ.
  - start is ignored in every other state.
- READ (4 cycles, word counter w = 0..3):
  - MEM_CEB = 0 with MEM_ADDR = BASE_ADDR + 4k + w.
  - MEM_ADDR increments each cycle.
  - The word issued in the previous cycle is captured into slot w-1.
  - After w = 3, go to LAST.
- LAST: capture word 3, MEM_CEB = 1, go to PRESENT.
- PRESENT:
  - out_valid = 1, tile_idx = k.
  - out_tile is stable until accepted.
  - On out_valid && out_ready:
    - if k < NUM_TILES-1: k++, go to READ next cycle.
    - else: go to DONE.
  - out_ready is ignored outside PRESENT.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE.
- Latency:
  - start in cycle 0 gives MEM_CEB low in cycles 1-4 (addresses 0-3) and out_valid from cycle 6.
  - Each subsequent tile is valid 6 cycles after the previous handshake.
- Address arithmetic is modulo 2^ADDR_W; BASE_ADDR + 4*NUM_TILES beyond 127 wraps to 0.
- out_tile slots are written only during capture; contents persist after the handshake.
- rst asserted mid-operation:
  - immediate return to IDLE and reset values, no further SRAM access.
  - A new start is required afterwards.
- out_ready held high continuously: no extra bubbles; the PRESENT dwell is 1 cycle.

Optional Feature:
- Macro: Q_TILE_NAN_CHECK_EN.
- Defined:
  - Extra output nan_err (1 bit, reset 0).
  - Set when any captured FP32 lane has exponent bits 8'hFF (NaN/Inf).
  - Sticky until the next accepted start or rst.
  - Set in the cycle after the offending word is captured.
- Not defined: port absent, no check logic.

Decomposition:
- Package q_proj_pkg holds:
  - constants WORD_W = 128, TILE_WORDS = 4, TILE_W = 512;
  - typedef enum rd_state_t {IDLE, READ, LAST, PRESENT, DONE}.
  - The Q-projection writer shares the tile constants from this package.
- No sub-module; the FSM and tile register stay in one module.

Test Plan:
- Preload SRAM word a = {4{a as 32-bit}}, pulse start with out_ready = 1:
  - MEM_CEB low cycles 1-4, addresses 0-3;
  - tile 0 lanes 0-3 = 0, lanes 12-15 = 3, out_valid at cycle 6;
  - 32 tiles total, last tile from addresses 124-127, done one cycle after the last handshake.
- Hold out_ready = 0 for 10 cycles on tile 2:
  - out_valid stays 1, out_tile and tile_idx = 2 stable, MEM_CEB stays 1;
  - release: tile 3 valid 6 cycles later.
- Pulse start while busy: ignored; tile sequence and address stream unchanged.
- Assert rst during READ of tile 5 (w = 2):
  - all outputs return to reset values the same cycle;
  - a later start reads from address 0 again.
- BASE_ADDR = 120, NUM_TILES = 4: addresses 120-127, then 0-7 (wrap).
- With Q_TILE_NAN_CHECK_EN, word 9 lane 1 = 32'h7FC00000: nan_err rises the cycle after that word's capture, stays high through done, clears on the next start.

Source files
------------

// File: rtl/q_proj_pkg.sv
// Shared constants and types for the Q-projection output SRAM (writer and reader sides).
package q_proj_pkg;

    localparam int unsigned WORD_W     = 128;
    localparam int unsigned TILE_WORDS = 4;
    localparam int unsigned TILE_W     = 512;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned WORD_LANES = WORD_W / LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
        PRESENT,
        DONE
    } rd_state_t;

    // True when any FP32 lane of a word has an all-ones exponent (NaN or Inf).
    function automatic logic word_has_nan(input logic [WORD_W-1:0] word);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < WORD_LANES; i++) begin
            if (word[LANE_W*i + 23 +: 8] == 8'hFF) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/q_tile_reader.sv
// Reads FP32 4x4 tiles back from the Q-projection SRAM and streams them downstream.
// Optional NaN/Inf flag on captured lanes: define Q_TILE_NAN_CHECK_EN.
module q_tile_reader
    import q_proj_pkg::*;
#(
    parameter int unsigned NUM_TILES = 32,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef Q_TILE_NAN_CHECK_EN
    output logic                  nan_err,
`endif
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [TILE_W-1:0]     out_tile,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            tile_idx,
    input  logic [WORD_W-1:0]     MEM_DOUT,
    output logic                  MEM_CEB,
    output logic                  MEM_WEN,
    output logic [ADDR_W-1:0]     MEM_ADDR,
    output logic [WORD_W-1:0]     MEM_DIN
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned W_W   = $clog2(TILE_WORDS);

    rd_state_t        state;
    logic [W_W-1:0]   w;
    logic [IDX_W-1:0] k;
    logic             capture;
    logic [W_W-1:0]   cap_slot;

    // Read data lags the issue by one cycle, so the slot being filled is always w-1
    // (w has wrapped to 0 in LAST, which makes slot 3).
    assign capture  = ((state == READ) && (w != '0)) || (state == LAST);
    assign cap_slot = w - W_W'(1);

    assign MEM_CEB = (state != READ);
    assign MEM_WEN = 1'b1;
    assign MEM_DIN = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_tile  <= '0;
            tile_idx  <= '0;
            MEM_ADDR  <= ADDR_W'(BASE_ADDR);
        end else begin
            done <= 1'b0;

            if (capture) begin
                out_tile[WORD_W*32'(cap_slot) +: WORD_W] <= MEM_DOUT;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        k        <= '0;
                        w        <= '0;
                        MEM_ADDR <= ADDR_W'(BASE_ADDR);
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    // Address keeps running across tiles; it wraps naturally at 2^ADDR_W.
                    MEM_ADDR <= MEM_ADDR + ADDR_W'(1);
                    w        <= w + W_W'(1);
                    if (w == W_W'(TILE_WORDS - 1)) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    out_valid <= 1'b1;
                    tile_idx  <= k;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (k < IDX_W'(NUM_TILES - 1)) begin
                            k     <= k + IDX_W'(1);
                            w     <= '0;
                            state <= READ;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef Q_TILE_NAN_CHECK_EN
    // Sticky flag, cleared only by an accepted start or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            nan_err <= 1'b0;
        end else if (capture && word_has_nan(MEM_DOUT)) begin
            nan_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_q_tile_reader.sv
// Self-checking bench for q_tile_reader: two instances (default map and a wrapping map)
// share one SRAM image; tiles, latency, address stream and done are checked against a model.
module tb_q_tile_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, start1, ready0, ready1;
    logic         busy0, busy1, done0, done1, valid0, valid1;
    logic [511:0] tile0, tile1;
    logic [4:0]   idx0, idx1;
    logic [127:0] dout0, dout1, din0, din1;
    logic         ceb0, ceb1, wen0, wen1;
    logic [6:0]   addr0, addr1;
`ifdef Q_TILE_NAN_CHECK_EN
    logic         nan0, nan1;
`endif

    q_tile_reader dut0 (
        .clk(clk), .rst(rst),
`ifdef Q_TILE_NAN_CHECK_EN
        .nan_err(nan0),
`endif
        .start(start0), .busy(busy0), .done(done0),
        .out_tile(tile0), .out_valid(valid0), .out_ready(ready0), .tile_idx(idx0),
        .MEM_DOUT(dout0), .MEM_CEB(ceb0), .MEM_WEN(wen0), .MEM_ADDR(addr0), .MEM_DIN(din0)
    );

    q_tile_reader #(.NUM_TILES(4), .ADDR_W(7), .BASE_ADDR(120)) dut1 (
        .clk(clk), .rst(rst),
`ifdef Q_TILE_NAN_CHECK_EN
        .nan_err(nan1),
`endif
        .start(start1), .busy(busy1), .done(done1),
        .out_tile(tile1), .out_valid(valid1), .out_ready(ready1), .tile_idx(idx1),
        .MEM_DOUT(dout1), .MEM_CEB(ceb1), .MEM_WEN(wen1), .MEM_ADDR(addr1), .MEM_DIN(din1)
    );

    // SRAM image and one-cycle read port per instance.
    logic [127:0] mem [128];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (!ceb0) dout0 <= mem[addr0];
        if (!ceb1) dout1 <= mem[addr1];
    end

    typedef struct { int c; int a; } iss_t;
    iss_t q0[$];
    iss_t q1[$];
    always @(negedge clk) begin
        if (!ceb0) q0.push_back('{cyc, int'(addr0)});
        if (!ceb1) q1.push_back('{cyc, int'(addr1)});
    end

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic         g_busy();  return sel == 1 ? busy1  : busy0;  endfunction
    function automatic logic         g_done();  return sel == 1 ? done1  : done0;  endfunction
    function automatic logic         g_valid(); return sel == 1 ? valid1 : valid0; endfunction
    function automatic logic [511:0] g_tile();  return sel == 1 ? tile1  : tile0;  endfunction
    function automatic logic [4:0]   g_idx();   return sel == 1 ? idx1   : idx0;   endfunction
    function automatic logic         g_ceb();   return sel == 1 ? ceb1   : ceb0;   endfunction
    function automatic logic         g_wen();   return sel == 1 ? wen1   : wen0;   endfunction
    function automatic logic [6:0]   g_addr();  return sel == 1 ? addr1  : addr0;  endfunction
    function automatic logic [127:0] g_din();   return sel == 1 ? din1   : din0;   endfunction
    function automatic int   qsize();           return sel == 1 ? q1.size() : q0.size(); endfunction
    function automatic iss_t qget(input int i); return sel == 1 ? q1[i] : q0[i];      endfunction

    task automatic set_start(input logic v); if (sel == 1) start1 = v; else start0 = v; endtask
    task automatic set_ready(input logic v); if (sel == 1) ready1 = v; else ready0 = v; endtask
    task automatic tick(); @(posedge clk); #1; endtask

    // Tile k is the four consecutive SRAM words starting at base + 4k, word 0 in the low bits.
    function automatic logic [511:0] exp_tile(input int base, input int k);
        logic [511:0] t;
        for (int i = 0; i < 4; i++) t[128*i +: 128] = mem[(base + 4*k + i) % 128];
        return t;
    endfunction

`ifdef Q_TILE_NAN_CHECK_EN
    function automatic logic g_nan(); return sel == 1 ? nan1 : nan0; endfunction
    function automatic logic has_nan(input logic [127:0] word);
        logic [31:0] lane;
        for (int l = 0; l < 4; l++) begin
            lane = word[32*l +: 32];
            if (lane[30:23] == 8'hFF) return 1'b1;
        end
        return 1'b0;
    endfunction
    // A word issued in cycle c is visible on the flag from cycle c+2 onward.
    function automatic logic exp_nan();
        iss_t e;
        for (int i = 0; i < qsize(); i++) begin
            e = qget(i);
            if (e.c <= cyc - 2 && has_nan(mem[e.a])) return 1'b1;
        end
        return 1'b0;
    endfunction
`endif

    task automatic fill_pattern();
        for (int a = 0; a < 128; a++) mem[a] = {4{32'(a)}};
    endtask

    // Random lanes with exponent MSB cleared so no lane is accidentally NaN/Inf.
    task automatic fill_random();
        for (int a = 0; a < 128; a++)
            for (int l = 0; l < 4; l++) mem[a][32*l +: 32] = $urandom() & 32'hBFFF_FFFF;
    endtask

    task automatic chk_reset(input int s);
        sel = s;
        chk("rst_busy", g_busy(), 0);
        chk("rst_done", g_done(), 0);
        chk("rst_valid", g_valid(), 0);
        chk("rst_ceb", g_ceb(), 1);
        chk("rst_wen", g_wen(), 1);
        chk("rst_addr", g_addr(), s == 1 ? 120 : 0);
        chk("rst_tile", g_tile(), 0);
        chk("rst_idx", g_idx(), 0);
        chk("rst_din", g_din(), 0);
`ifdef Q_TILE_NAN_CHECK_EN
        chk("rst_nan", g_nan(), 0);
`endif
    endtask

    // One full readout: start, drain ntiles with the given ready policy, then check done and addresses.
    task automatic run(input int s, input int ntiles, input int base, input bit rnd,
                       input int hold_tile, input int poke);
        int   t0, ref_c, k, hold_cnt;
        bit   seen;
        logic r;
        sel = s;
        if (s == 1) q1.delete(); else q0.delete();
        set_start(1'b1);
        t0 = cyc;
        tick();
        set_start(1'b0);
        chk("busy_after_start", g_busy(), 1);
        k = 0; ref_c = t0; seen = 0; hold_cnt = 0;
        while (k < ntiles && cyc - t0 < ntiles * 40 + 200) begin
            set_start(poke == cyc - t0);
            if (g_valid()) begin
                if (!seen) begin
                    chk("valid_latency", cyc - ref_c, 6);
                    seen = 1;
                end
                chk("tile_data", g_tile(), exp_tile(base, k));
                chk("tile_idx", g_idx(), k);
                chk("ceb_in_present", g_ceb(), 1);
                if (k == hold_tile && hold_cnt < 10) begin
                    r = 1'b0;
                    hold_cnt++;
                end else begin
                    r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end else begin
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            set_ready(r);
            if (g_valid() && r) begin
                ref_c = cyc;
                k++;
                seen = 0;
            end
`ifdef Q_TILE_NAN_CHECK_EN
            chk("nan_err", g_nan(), exp_nan());
`endif
            tick();
        end
        set_start(1'b0);
        chk("tiles_accepted", k, ntiles);
        chk("done_pulse", g_done(), 1);
        chk("busy_at_done", g_busy(), 0);
        chk("valid_at_done", g_valid(), 0);
`ifdef Q_TILE_NAN_CHECK_EN
        chk("nan_at_done", g_nan(), exp_nan());
`endif
        tick();
        chk("done_one_cycle", g_done(), 0);
        chk("issue_count", qsize(), 4 * ntiles);
        for (int i = 0; i < qsize() && i < 4 * ntiles; i++)
            chk("issue_addr", qget(i).a, (base + i) % 128);
        for (int i = 0; i < qsize() && i < 4; i++)
            chk("first_issue_cycle", qget(i).c - t0, i + 1);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        #2;
        chk_reset(0);
        chk_reset(1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Address-pattern image, ready held high.
        fill_pattern();
        run(0, 32, 0, 1'b0, -1, -1);
        tick();

        // Reset while reading word 2 of tile 5.
        sel = 0;
        fill_random();
        set_ready(1'b1);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (32) tick();
        chk("ceb_before_rst", ceb0, 0);
        chk("addr_before_rst", addr0, 22);
        #1 rst = 1'b1;
        #1;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        repeat (5) tick();
        chk("no_access_after_rst", q0.size(), 0);
        chk("idle_after_rst", busy0, 0);

        // Random image with one NaN lane, stall on tile 2, stray start while busy.
        fill_random();
        mem[9][63:32] = 32'h7FC0_0000;
        run(0, 32, 0, 1'b0, 2, 20);
        tick();

        // Clean random image, random ready; flag must clear on the new start.
        fill_random();
        run(0, 32, 0, 1'b1, -1, -1);
        tick();

        // Wrapping map: 120..127 then 0..7.
        fill_random();
        run(1, 4, 120, 1'b1, -1, -1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
